// File: rtl/bus_endpoint_fifo.sv
// bus_endpoint_fifo: device-side bus endpoint with a TX FIFO (host -> bus)
// and an address-filtered RX FIFO (bus -> host). Both FIFOs are circular
// buffers with first-word-fall-through heads; empty heads read as 0.
// Optional build macro BUS_EP_DROP_CNT_EN adds a saturating 16-bit drop_cnt
// output counting RX packets lost on full and TX writes dropped on full.
module bus_endpoint_fifo #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DEPTH  = 8,
   parameter logic [7:0]  DEV_ID = 8'h00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             tx_full,
   output logic             pndng,
   input  logic             pop,
   output logic [WIDTH-1:0] D_pop,
   input  logic             push,
   input  logic [WIDTH-1:0] D_push,
   output logic             rx_valid,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rx_overflow
`ifdef BUS_EP_DROP_CNT_EN
   ,
   output logic [15:0]      drop_cnt
`endif
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [7:0]  BCAST_ID = 8'hFF;

   logic [WIDTH-1:0] tx_mem_q [DEPTH];
   logic [WIDTH-1:0] tx_mem_d [DEPTH];
   logic [AW-1:0]    tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [AW:0]      tx_cnt_q, tx_cnt_d;

   logic [WIDTH-1:0] rx_mem_q [DEPTH];
   logic [WIDTH-1:0] rx_mem_d [DEPTH];
   logic [AW-1:0]    rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [AW:0]      rx_cnt_q, rx_cnt_d;

   logic             rx_ovf_q, rx_ovf_d;

   logic             tx_do_wr, tx_do_rd;
   logic             rx_match, rx_do_wr, rx_do_rd, rx_lost;

   // Flags and heads come only from registered state
   assign tx_full     = (tx_cnt_q == FULL_CNT);
   assign pndng       = (tx_cnt_q != '0);
   assign D_pop       = pndng ? tx_mem_q[tx_rptr_q] : '0;
   assign rx_valid    = (rx_cnt_q != '0);
   assign rd_data     = rx_valid ? rx_mem_q[rx_rptr_q] : '0;
   assign rx_overflow = rx_ovf_q;

   // Handshake qualification: a full FIFO still accepts a write when the same cycle pops
   always_comb begin
      tx_do_rd = pop & pndng;
      tx_do_wr = wr_en & (~tx_full | tx_do_rd);
      rx_match = push & ((D_push[WIDTH-1 -: 8] == DEV_ID) | (D_push[WIDTH-1 -: 8] == BCAST_ID));
      rx_do_rd = rd_en & rx_valid;
      rx_do_wr = rx_match & (~(rx_cnt_q == FULL_CNT) | rx_do_rd);
      rx_lost  = rx_match & ~rx_do_wr;
   end

   // TX FIFO next state
   always_comb begin
      tx_mem_d  = tx_mem_q;
      tx_wptr_d = tx_wptr_q;
      tx_rptr_d = tx_rptr_q;
      tx_cnt_d  = tx_cnt_q;
      if (tx_do_wr) begin
         tx_mem_d[tx_wptr_q] = wr_data;
         tx_wptr_d           = tx_wptr_q + AW'(1);
      end
      if (tx_do_rd) begin
         tx_rptr_d = tx_rptr_q + AW'(1);
      end
      case ({tx_do_wr, tx_do_rd})
         2'b10:   tx_cnt_d = tx_cnt_q + (AW+1)'(1);
         2'b01:   tx_cnt_d = tx_cnt_q - (AW+1)'(1);
         default: tx_cnt_d = tx_cnt_q;
      endcase
   end

   // RX FIFO next state and sticky overflow
   always_comb begin
      rx_mem_d  = rx_mem_q;
      rx_wptr_d = rx_wptr_q;
      rx_rptr_d = rx_rptr_q;
      rx_cnt_d  = rx_cnt_q;
      rx_ovf_d  = rx_ovf_q | rx_lost;
      if (rx_do_wr) begin
         rx_mem_d[rx_wptr_q] = D_push;
         rx_wptr_d           = rx_wptr_q + AW'(1);
      end
      if (rx_do_rd) begin
         rx_rptr_d = rx_rptr_q + AW'(1);
      end
      case ({rx_do_wr, rx_do_rd})
         2'b10:   rx_cnt_d = rx_cnt_q + (AW+1)'(1);
         2'b01:   rx_cnt_d = rx_cnt_q - (AW+1)'(1);
         default: rx_cnt_d = rx_cnt_q;
      endcase
   end

   // State registers, asynchronously cleared
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tx_mem_q[i] <= '0;
            rx_mem_q[i] <= '0;
         end
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         tx_cnt_q  <= '0;
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         rx_cnt_q  <= '0;
         rx_ovf_q  <= 1'b0;
      end else begin
         tx_mem_q  <= tx_mem_d;
         tx_wptr_q <= tx_wptr_d;
         tx_rptr_q <= tx_rptr_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_mem_q  <= rx_mem_d;
         rx_wptr_q <= rx_wptr_d;
         rx_rptr_q <= rx_rptr_d;
         rx_cnt_q  <= rx_cnt_d;
         rx_ovf_q  <= rx_ovf_d;
      end
   end

`ifdef BUS_EP_DROP_CNT_EN
   logic        tx_drop;
   logic [16:0] drop_sum;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   assign drop_cnt = drop_cnt_q;

   // Saturating loss counter; both loss events in one cycle add 2
   always_comb begin
      tx_drop    = wr_en & ~tx_do_wr;
      drop_sum   = {1'b0, drop_cnt_q} + 17'(tx_drop) + 17'(rx_lost);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   // Drop counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) drop_cnt_q <= '0;
      else       drop_cnt_q <= drop_cnt_d;
   end
`endif

endmodule
